// File: rtl/da_spi_tx_pkg.sv
// Shared definitions for the DAC SPI transmitter. The frame timing defaults are
// the same ones the ADC capture front end uses, so both converters see identical frames.
package da_spi_tx_pkg;

  localparam logic [2:0] S_IDLE        = 3'd0;
  localparam logic [2:0] S_FRONT_PORCH = 3'd1;
  localparam logic [2:0] S_SHIFTING    = 3'd2;
  localparam logic [2:0] S_BACK_PORCH  = 3'd3;
  localparam logic [2:0] S_HOLD        = 3'd4;

  localparam int BITS_PER_TRANSACTION = 16;

  localparam int DEF_CLOCKS_PER_BIT              = 5;
  localparam int DEF_CLOCKS_BEFORE_DATA          = 5;
  localparam int DEF_CLOCKS_AFTER_DATA           = 5;
  localparam int DEF_CLOCKS_BETWEEN_TRANSACTIONS = 10;

endpackage

// File: rtl/da_spi_tx.sv
// Serial transmitter writing 16-bit MSB-first frames to a DAC, with a one-entry
// holding buffer so the next sample can be queued while the current one shifts.
//
// state         | meaning
// S_IDLE        | cs high, waiting for a buffered word
// S_FRONT_PORCH | cs low, settling time before the first bit
// S_SHIFTING    | cs low, 16 bits clocked out on sclk
// S_BACK_PORCH  | cs low, settling time after the last bit
// S_HOLD        | cs high, minimum gap between frames; also the reset state
module da_spi_tx
  import da_spi_tx_pkg::*;
#(
  parameter int INCLUDE_DEBUG_INTERFACE     = 1,
  parameter int CLOCKS_PER_BIT              = DEF_CLOCKS_PER_BIT,
  parameter int CLOCKS_BEFORE_DATA          = DEF_CLOCKS_BEFORE_DATA,
  parameter int CLOCKS_AFTER_DATA           = DEF_CLOCKS_AFTER_DATA,
  parameter int CLOCKS_BETWEEN_TRANSACTIONS = DEF_CLOCKS_BETWEEN_TRANSACTIONS
) (
  input  logic        clk_100M,
  input  logic        rst,
  input  logic [15:0] din,
  input  logic        din_valid,
  output logic        din_ready,
  output logic        cs,
  output logic        sclk,
  output logic        sdout,
  output logic        busy,
  output logic        done,
  output logic [2:0]  led
);

  localparam logic [31:0] LAST_BIT_CLK = 32'(CLOCKS_PER_BIT - 1);
  localparam logic [31:0] LAST_FRONT   = 32'(CLOCKS_BEFORE_DATA - 1);
  localparam logic [31:0] LAST_BACK    = 32'(CLOCKS_AFTER_DATA - 1);
  localparam logic [31:0] LAST_HOLD    = 32'(CLOCKS_BETWEEN_TRANSACTIONS - 1);
  localparam logic [31:0] LAST_BIT_IDX = 32'(BITS_PER_TRANSACTION - 1);
  localparam logic [31:0] HALF         = 32'(CLOCKS_PER_BIT >> 1);

  logic [2:0]  state_q, state_d;
  logic [31:0] count0_q, count0_d;
  logic [31:0] count1_q, count1_d;
  logic [15:0] sreg_q, sreg_d;
  logic [15:0] buf_q, buf_d;
  logic        buf_full_q, buf_full_d;
  logic        done_q, done_d;

  always_comb begin
    state_d    = state_q;
    count0_d   = count0_q;
    count1_d   = count1_q;
    sreg_d     = sreg_q;
    buf_d      = buf_q;
    buf_full_d = buf_full_q;
    done_d     = 1'b0;

    // Accept only into an empty buffer; IDLE only drains a full one, so they never collide.
    if (din_valid && !buf_full_q) begin
      buf_d      = din;
      buf_full_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (buf_full_q) begin
          sreg_d     = buf_q;
          buf_full_d = 1'b0;
          count0_d   = '0;
          state_d    = S_FRONT_PORCH;
        end
      end
      S_FRONT_PORCH: begin
        if (count0_q == LAST_FRONT) begin
          count0_d = '0;
          count1_d = '0;
          state_d  = S_SHIFTING;
        end else begin
          count0_d = count0_q + 32'd1;
        end
      end
      S_SHIFTING: begin
        if (count0_q == LAST_BIT_CLK) begin
          count0_d = '0;
          if (count1_q == LAST_BIT_IDX) begin
            state_d = S_BACK_PORCH;
          end else begin
            count1_d = count1_q + 32'd1;
            sreg_d   = {sreg_q[14:0], 1'b0};
          end
        end else begin
          count0_d = count0_q + 32'd1;
        end
      end
      S_BACK_PORCH: begin
        if (count0_q == LAST_BACK) begin
          count0_d = '0;
          done_d   = 1'b1;
          state_d  = S_HOLD;
        end else begin
          count0_d = count0_q + 32'd1;
        end
      end
      S_HOLD: begin
        if (count0_q == LAST_HOLD) begin
          count0_d = '0;
          state_d  = S_IDLE;
        end else begin
          count0_d = count0_q + 32'd1;
        end
      end
      default: begin
        count0_d = '0;
        state_d  = S_HOLD;
      end
    endcase
  end

  always_ff @(posedge clk_100M) begin
    if (rst) begin
      state_q    <= S_HOLD;
      count0_q   <= '0;
      count1_q   <= '0;
      sreg_q     <= '0;
      buf_q      <= '0;
      buf_full_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      count0_q   <= count0_d;
      count1_q   <= count1_d;
      sreg_q     <= sreg_d;
      buf_q      <= buf_d;
      buf_full_q <= buf_full_d;
      done_q     <= done_d;
    end
  end

  assign din_ready = !buf_full_q;
  assign cs        = !((state_q == S_FRONT_PORCH) || (state_q == S_SHIFTING) ||
                       (state_q == S_BACK_PORCH));
  // Bit is driven from count0=0, so it is stable well before the falling edge at HALF.
  assign sclk      = !((state_q == S_SHIFTING) && (count0_q >= HALF));
  assign sdout     = (state_q == S_SHIFTING) ? sreg_q[15] : 1'b0;
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;

  generate
    if (INCLUDE_DEBUG_INTERFACE == 1) begin : g_led
      assign led = state_q;
    end else begin : g_no_led
      assign led = 3'b000;
    end
  endgenerate

endmodule

// File: tb/tb_da_spi_tx.sv
// Directed self-checking bench for da_spi_tx: default timing, a fast-timing
// instance and an instance with the debug LEDs compiled out.
module tb_da_spi_tx;

  logic        clk_100M = 1'b0;
  logic        rst = 1'b1, rst1 = 1'b1;
  logic [15:0] din = '0, din1 = '0;
  logic        din_valid = 1'b0, din_valid1 = 1'b0;

  logic din_ready0, cs0, sclk0, sdout0, busy0, done0;
  logic din_ready1, cs1, sclk1, sdout1, busy1, done1;
  logic din_ready2, cs2, sclk2, sdout2, busy2, done2;
  logic [2:0] led0, led1, led2;

  int checks = 0;
  int errors = 0;

  always #5 clk_100M = ~clk_100M;

  da_spi_tx dut0 (
    .clk_100M(clk_100M), .rst(rst), .din(din), .din_valid(din_valid),
    .din_ready(din_ready0), .cs(cs0), .sclk(sclk0), .sdout(sdout0),
    .busy(busy0), .done(done0), .led(led0)
  );

  da_spi_tx #(
    .CLOCKS_PER_BIT(2), .CLOCKS_BEFORE_DATA(1), .CLOCKS_AFTER_DATA(1),
    .CLOCKS_BETWEEN_TRANSACTIONS(1)
  ) dut1 (
    .clk_100M(clk_100M), .rst(rst1), .din(din1), .din_valid(din_valid1),
    .din_ready(din_ready1), .cs(cs1), .sclk(sclk1), .sdout(sdout1),
    .busy(busy1), .done(done1), .led(led1)
  );

  da_spi_tx #(.INCLUDE_DEBUG_INTERFACE(0)) dut2 (
    .clk_100M(clk_100M), .rst(rst), .din(din), .din_valid(din_valid),
    .din_ready(din_ready2), .cs(cs2), .sclk(sclk2), .sdout(sdout2),
    .busy(busy2), .done(done2), .led(led2)
  );

  task automatic step();
    @(negedge clk_100M);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic cs_of(input int sel);
    return (sel == 0) ? cs0 : cs1;
  endfunction

  // Follows one frame: cycles of cs high before it, cs-low length, bits at sclk falls.
  task automatic capture(input int sel, input int max_wait,
                         output logic [15:0] word, output int wait_c, output int low_c,
                         output int falls, output int sclk_low, output int done_low,
                         output logic done_rise, output logic [11:0] led_seq,
                         output logic led2_bad);
    logic c, s, d, prev_s;
    logic [2:0] prev_l;
    word = '0; wait_c = 0; low_c = 0; falls = 0; sclk_low = 0; done_low = 0;
    done_rise = 1'b0; led_seq = '0; led2_bad = 1'b0; prev_s = 1'b1; prev_l = 3'h7;
    c = cs_of(sel);
    while (c && wait_c < max_wait) begin
      step();
      wait_c++;
      c = cs_of(sel);
    end
    chk("cs_fall_in_time", 32'(c), 32'd0);
    if (c) return;
    while (!c && low_c < 400) begin
      s = (sel == 0) ? sclk0 : sclk1;
      d = (sel == 0) ? sdout0 : sdout1;
      if (led2 != 3'd0) led2_bad = 1'b1;
      if (led0 != prev_l) begin
        led_seq = {led_seq[8:0], led0};
        prev_l  = led0;
      end
      if (prev_s && !s) begin
        word = {word[14:0], d};
        falls++;
      end
      if (!s) sclk_low++;
      if ((sel == 0) ? done0 : done1) done_low++;
      prev_s = s;
      low_c++;
      step();
      c = cs_of(sel);
    end
    done_rise = (sel == 0) ? done0 : done1;
    led_seq   = {led_seq[8:0], led0};
    if (led2 != 3'd0) led2_bad = 1'b1;
  endtask

  logic [15:0] word;
  int          wait_c, low_c, falls, sclk_low, done_low, n, lows, dones;
  logic        done_rise, led2_bad, rdy;
  logic [11:0] led_seq;
  logic [15:0] stream [3] = '{16'h0001, 16'hFFFF, 16'h8000};

  initial begin
    // Reset state
    step();
    chk("rst_cs", 32'(cs0), 32'd1);
    chk("rst_sclk", 32'(sclk0), 32'd1);
    chk("rst_sdout", 32'(sdout0), 32'd0);
    chk("rst_done", 32'(done0), 32'd0);
    chk("rst_ready", 32'(din_ready0), 32'd1);
    chk("rst_busy", 32'(busy0), 32'd1);
    chk("rst_led", 32'(led0), 32'd4);
    chk("rst_led_nodbg", 32'(led2), 32'd0);
    chk("rst_led_fast", 32'(led1), 32'd4);
    rst = 1'b0; rst1 = 1'b0;
    repeat (12) step();
    chk("idle_busy", 32'(busy0), 32'd0);
    chk("idle_led", 32'(led0), 32'd0);
    chk("idle_cs", 32'(cs0), 32'd1);
    chk("fast_idle_busy", 32'(busy1), 32'd0);

    // Single frame A5C3
    din = 16'hA5C3; din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    chk("accept_ready_low", 32'(din_ready0), 32'd0);
    capture(0, 20, word, wait_c, low_c, falls, sclk_low, done_low, done_rise, led_seq, led2_bad);
    chk("a5c3_cs_latency", 32'(wait_c + 1), 32'd2);
    chk("a5c3_word", 32'(word), 32'hA5C3);
    chk("a5c3_falls", 32'(falls), 32'd16);
    chk("a5c3_cs_low", 32'(low_c), 32'd90);
    chk("a5c3_sclk_low", 32'(sclk_low), 32'd48);
    chk("a5c3_done_in_frame", 32'(done_low), 32'd0);
    chk("a5c3_done_at_rise", 32'(done_rise), 32'd1);
    chk("a5c3_led_seq", 32'(led_seq), 32'h29C);
    chk("nodbg_led_zero", 32'(led2_bad), 32'd0);

    // Streaming three words with din_valid held high
    fork
      begin
        for (int i = 0; i < 3; i++) begin
          din = stream[i]; din_valid = 1'b1;
          n = 0; rdy = din_ready0;
          while (!rdy && n < 300) begin
            step(); n++; rdy = din_ready0;
          end
          step();
          chk("stream_ready_drop", 32'(din_ready0), 32'd0);
        end
        din_valid = 1'b0;
      end
      begin
        for (int i = 0; i < 3; i++) begin
          capture(0, 30, word, wait_c, low_c, falls, sclk_low, done_low, done_rise, led_seq, led2_bad);
          chk("stream_word", 32'(word), 32'(stream[i]));
          chk("stream_cs_high", 32'(wait_c), 32'd11);
          chk("stream_cs_low", 32'(low_c), 32'd90);
        end
      end
    join

    // din changes while not ready: only accepted words are sent
    fork
      begin
        din = 16'h1111; din_valid = 1'b1;
        step();
        chk("hold_ready_low", 32'(din_ready0), 32'd0);
        n = 0;
        while (!din_ready0 && n < 300) begin
          din = 16'h2000 + 16'(n);
          step(); n++;
        end
        din = 16'hBEEF;
        step();
        din_valid = 1'b0;
      end
      begin
        capture(0, 30, word, wait_c, low_c, falls, sclk_low, done_low, done_rise, led_seq, led2_bad);
        chk("hold_word1", 32'(word), 32'h1111);
        capture(0, 30, word, wait_c, low_c, falls, sclk_low, done_low, done_rise, led_seq, led2_bad);
        chk("hold_word2", 32'(word), 32'hBEEF);
        chk("hold_gap2", 32'(wait_c), 32'd11);
      end
    join
    lows = 0; dones = 0;
    repeat (150) begin
      step();
      if (!cs0) lows++;
      if (done0) dones++;
    end
    chk("no_extra_frame", 32'(lows), 32'd0);
    chk("done_single_cycle", 32'(dones), 32'd0);

    // Reset mid-shift at bit 7 of 1234, with ABCD sitting in the buffer
    din = 16'h1234; din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    n = 0;
    while (cs0 && n < 20) begin step(); n++; end
    chk("rst_frame_started", 32'(cs0), 32'd0);
    din = 16'hABCD; din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    repeat (4 + 35) step();
    chk("midshift_buf_full", 32'(din_ready0), 32'd0);
    chk("midshift_cs", 32'(cs0), 32'd0);
    rst = 1'b1;
    step();
    chk("midrst_cs", 32'(cs0), 32'd1);
    chk("midrst_sclk", 32'(sclk0), 32'd1);
    chk("midrst_sdout", 32'(sdout0), 32'd0);
    chk("midrst_ready", 32'(din_ready0), 32'd1);
    chk("midrst_done", 32'(done0), 32'd0);
    chk("midrst_led", 32'(led0), 32'd4);
    rst = 1'b0;
    din = 16'h0F0F; din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    capture(0, 30, word, wait_c, low_c, falls, sclk_low, done_low, done_rise, led_seq, led2_bad);
    chk("postrst_cs_high", 32'(wait_c + 1), 32'd11);
    chk("postrst_word", 32'(word), 32'h0F0F);
    chk("postrst_cs_low", 32'(low_c), 32'd90);

    // Fast timing instance
    din1 = 16'h5555; din_valid1 = 1'b1;
    step();
    din_valid1 = 1'b0;
    capture(1, 20, word, wait_c, low_c, falls, sclk_low, done_low, done_rise, led_seq, led2_bad);
    chk("fast_latency", 32'(wait_c), 32'd1);
    chk("fast_word", 32'(word), 32'h5555);
    chk("fast_falls", 32'(falls), 32'd16);
    chk("fast_sclk_low", 32'(sclk_low), 32'd16);
    chk("fast_cs_low", 32'(low_c), 32'd34);
    chk("fast_done", 32'(done_rise), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/da_spi_tx.md
Name: da_spi_tx

Overview:
- SPI-style serial transmitter that writes 16-bit frames, MSB first, to an external DAC.
- It is the write-direction counterpart of the team's ADC capture front end and uses the same frame timing: hold, front porch, shifting, back porch.
- A one-entry holding buffer with a valid/ready handshake lets the next sample be queued while the current frame is shifting.

Parameters:
- INCLUDE_DEBUG_INTERFACE, 1, 1 drives led with the state encoding; 0 drives led to 0.
- CLOCKS_PER_BIT, 5, clk_100M cycles per serial bit (50 ns); must be >= 2.
- CLOCKS_BEFORE_DATA, 5, cycles from cs falling to the first bit (50 ns).
- CLOCKS_AFTER_DATA, 5, cycles from the end of the last bit to cs rising (50 ns).
- CLOCKS_BETWEEN_TRANSACTIONS, 10, minimum cycles with cs high between frames (100 ns).

Ports:
- clk_100M  in  1  system clock, 100 MHz.
- rst  in  1  synchronous, active-high reset.
- din  in  16  frame to send, MSB first.
- din_valid  in  1  din is presented.
- din_ready  out  1  holding buffer empty; equals !buf_full.
- cs  out  1  chip select, active low.
- sclk  out  1  serial clock; idles high; DAC samples sdout on the falling edge.
- sdout  out  1  serial data.
- busy  out  1  high whenever state is not S_IDLE.
- done  out  1  one-cycle pulse at the end of each frame.
- led  out  3  debug view of the state.

Behaviour:
- Reset (synchronous, rst=1), effective next clock:
  - state=S_HOLD, count0=0, count1=0, sreg=0, buffer emptied.
  - cs=1, sclk=1, sdout=0, done=0, din_ready=1, busy=1.
  - Reset mid-frame aborts the frame immediately, drops the buffered word, and restarts the full hold time.
- Handshake:
  - A word is accepted on any clock with din_valid & din_ready; buf_full is set the next cycle.
  - Consumption only happens when buf_full=1 and acceptance only when buf_full=0, so the two never coincide.
  - din_valid while din_ready=0 is ignored; the source must hold the word.
- States and transitions:
  - S_IDLE=0: cs=1. If buf_full, load sreg<=buf, clear buf_full, count0<=0, go to S_FRONT_PORCH.
  - S_FRONT_PORCH=1: cs=0. Count to CLOCKS_BEFORE_DATA-1, then count0<=0, count1<=0, go to S_SHIFTING.
  - S_SHIFTING=2: cs=0. count0 runs 0..CLOCKS_PER_BIT-1 per bit.
    - At count0==CLOCKS_PER_BIT-1: count0<=0.
    - If count1==15, go to S_BACK_PORCH.
    - Otherwise count1<=count1+1 and sreg<={sreg[14:0],1'b0}.
  - S_BACK_PORCH=3: cs=0. Count to CLOCKS_AFTER_DATA-1, then count0<=0, done<=1, go to S_HOLD.
  - S_HOLD=4: cs=1. done is high only in the first HOLD cycle. Count to CLOCKS_BETWEEN_TRANSACTIONS-1, then go to S_IDLE.
- Bit timing:
  - HALF=CLOCKS_PER_BIT>>1.
  - sclk=0 only when state==S_SHIFTING and count0>=HALF; otherwise sclk=1.
  - sdout=sreg[15] in S_SHIFTING, else 0. The bit is stable from count0=0 through the falling edge at count0=HALF and until the next bit start.
  - With defaults: sclk is high 2 cycles and low 3 cycles per bit.
- Latency:
  - If buf_full=1 in S_IDLE at cycle N, cs falls at N+1.
  - cs stays low for CLOCKS_BEFORE_DATA+16*CLOCKS_PER_BIT+CLOCKS_AFTER_DATA cycles (90 with defaults).
  - cs is then high for at least CLOCKS_BETWEEN_TRANSACTIONS cycles (10).
  - Back-to-back frame period with defaults: 90+10+1 (IDLE) = 101 cycles.
- Buffering: the buffer may be refilled during any state after S_IDLE consumes it. A word written during a frame is sent in the next frame with no gap beyond S_HOLD plus one S_IDLE cycle.
- Counters: count0 and count1 are 32-bit unsigned. No wrap occurs within parameter limits.
- led: {state[2:0]} when INCLUDE_DEBUG_INTERFACE==1, else 3'b000.

Decomposition:
- Shared package holds:
  - state encodings S_IDLE..S_HOLD (3-bit);
  - BITS_PER_TRANSACTION=16;
  - the default timing constants shared with the ADC receiver, so both front ends use identical frame timing.
- No sub-module. The holding buffer and bit timer are small and stay inline.

Test Plan:
- Reset release, then din=16'hA5C3 with one valid pulse:
  - cs falls exactly 2 cycles after acceptance;
  - 16 sclk falling edges;
  - sdout sampled at the falls reads 1010010111000011;
  - cs is low for 90 cycles;
  - done pulses once, on the cycle cs rises.
- Streaming 16'h0001, 16'hFFFF, 16'h8000 with din_valid held high:
  - din_ready drops after each accept and reasserts when S_IDLE consumes the word;
  - frames are sent in order;
  - cs is high for exactly 11 cycles between frames.
- din_valid held while din_ready=0 with a changing din: only the word present at the accepting cycle is sent; no words are duplicated or lost.
- rst asserted mid-shift at bit 7 of 16'h1234:
  - next cycle cs=1, sclk=1, sdout=0, din_ready=1;
  - no done pulse;
  - the next frame starts only after 10 HOLD cycles plus IDLE.
- Parameter override CLOCKS_PER_BIT=2, CLOCKS_BEFORE_DATA=1, CLOCKS_AFTER_DATA=1, CLOCKS_BETWEEN_TRANSACTIONS=1, din=16'h5555:
  - sclk is high 1 cycle and low 1 cycle per bit;
  - cs is low for 34 cycles;
  - sdout alternates 0,1 at successive falling edges.
- INCLUDE_DEBUG_INTERFACE=0: led is constant 0 throughout a frame. With the default of 1, led steps through 4,0,1,2,3,4 across one frame.
